alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered decode/issue stage that drives the ALU's control and operand-select inputs. It accepts 32-bit MIPS instructions from fetch over a valid/ready handshake and decodes each into the ALU operation code, signedness, operand selects and extended immediate. It presents them to the execute stage through a two-entry skid buffer, so full throughput is kept under downstream stalls. It also supports a synchronous pipeline flush.

## Interface
Parameters:
- none; all encodings come from `alu_pkg`.

Ports:
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRst_n`  in  1  reset, synchronous, active-low.
- `iInstr`  in  32  instruction word from fetch.
- `iValid`  in  1  `iInstr` is valid.
- `oReady`  out  1  stage can accept; registered.
- `iFlush`  in  1  discard all held and incoming instructions.
- `iReady`  in  1  execute stage consumes the current output.
- `oValid`  out  1  output fields are valid.
- `oALUFun`  out  6  ALU operation code.
- `oSign`  out  1  signed compare / overflow-checked arithmetic.
- `oASel`  out  2  ALU A source: 0 = rs, 1 = shamt, 2 = constant 16.
- `oBSel`  out  2  ALU B source: 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = zero.
- `oImm32`  out  32  extended immediate, per `oBSel`.
- `oShamt`  out  5  instr[10:6].
- `oRs`, `oRt`, `oRd`  out  5 each  register fields.
- `oIllegal`  out  1  unsupported encoding.

## Operation
ALUFun codes:
- Arithmetic: ADD 000000, SUB 000001.
- Logic: AND 011000, OR 011110, XOR 010110, NOR 010001, STA 011010.
- Shift: SLL 100000, SRL 100001, SRA 100011.
- Compare: EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.

R-type (opcode 0), decoded by funct:
- add 0x20 → ADD, Sign 1; addu 0x21 → ADD, Sign 0.
- sub 0x22 → SUB, Sign 1; subu 0x23 → SUB, Sign 0.
- and/or/xor/nor 0x24–0x27 → matching logic op.
- slt 0x2A → LT, Sign 1; sltu 0x2B → LT, Sign 0.
- sll 0x00 / srl 0x02 / sra 0x03 → matching shift, ASel = shamt, B = rt.
- jr 0x08 → STA.

I-type, decoded by opcode:
- addi 0x08 → ADD, Sign 1, sext; addiu 0x09 → ADD, Sign 0, sext.
- slti 0x0A → LT, Sign 1, sext; sltiu 0x0B → LT, Sign 0, sext.
- andi 0x0C / ori 0x0D / xori 0x0E → matching logic op, zext.
- lui 0x0F → SLL, ASel = 16, zext.
- lw 0x23 / sw 0x2B → ADD, Sign 0, sext.
- beq 0x04 → EQ; bne 0x05 → NEQ; blez 0x06 → LEZ; bgtz 0x07 → GTZ. All Sign 1.
- REGIMM 0x01: rt = 1 → GEZ; rt = 0 → LT with BSel = 3. Both Sign 1.

Illegal / unlisted encodings: oIllegal = 1, ALUFun ADD, Sign 0, selects 0. The entry still flows through the pipeline.

Output fields not defined for an encoding: Sign 0, ASel 0, BSel 0.

Buffering:
- Main entry M drives the outputs; skid entry S is behind it.
- Input accepted when iValid && oReady.
- Output consumed when oValid && iReady.
- Next-state oReady = !S_valid_next.

## Timing
- Reset: all outputs 0 on the first edge with iRst_n = 0, including oReady. oReady rises one cycle after reset deasserts.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (registered, 1 cycle) when M is free or being consumed.
- Accept while M is valid and not consumed: the instruction is written to S; oReady goes 0 after that edge.
- M consumed while S is valid: S moves to M; oReady returns to 1 after that edge.
- Simultaneous accept and consume with S empty: the new instruction goes into M. Full throughput, 1 instruction per cycle.
- Output fields are stable while oValid && !iReady.
- Order is strictly FIFO; no drop and no duplication.
- iFlush = 1 at an edge: M and S are invalidated and any same-cycle accept is discarded. Flush wins over the handshake. oValid = 0 and oReady = 1 after that edge.
- Reset asserted mid-stall: same result as flush, except oReady = 0 for the reset cycle.

## Structure
- `alu_pkg` holds:
  - the ALUFun code localparams;
  - opcode and funct constants;
  - ASel/BSel encodings;
  - the decoded-bundle typedef (ALUFun, Sign, ASel, BSel, Imm32, Shamt, Rs, Rt, Rd, Illegal).
- Sub-module `mips_alu_decode`: purely combinational, iInstr → bundle.
- `alu_issue_stage` holds the two bundle registers, the valid bits and the handshake logic.

## Test plan
- Decode, add: 0x00221820 (add $3,$1,$2) → ALUFun 000000, Sign 1, ASel 0, BSel 0, Rs 1, Rt 2, Rd 3, oIllegal 0.
- Decode, lui and addi: 0x3C011234 (lui) → SLL, ASel 2, BSel 2, Imm32 0x00001234. 0x2021FFFF (addi) → ADD, Sign 1, BSel 1, Imm32 0xFFFFFFFF.
- Illegal and REGIMM:
  - 0xFC000000 → oIllegal 1, ALUFun 000000.
  - bltz 0x04200003 → LT, BSel 3.
  - bgez 0x04210003 → GEZ.
- Backpressure: continuous iValid with instructions I0..I5; iReady = 0 for 3 cycles → oReady falls after one stalled accept and outputs hold I_k. After release, all six emerge in order with no gaps once streaming.
- Flush: S and M full, iFlush = 1 together with iValid → next cycle oValid 0, oReady 1. The next instruction accepted appears one cycle later with no remnants of flushed entries.
- Reset: iRst_n = 0 mid-stall → outputs 0 and oReady 0. oReady = 1 one cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS decode/issue slice: ALU function codes, opcode/funct
// constants, operand-select encodings and the decoded bundle carried through the stage.
package alu_pkg;

    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_XOR = 6'b010110;
    localparam logic [5:0] FUN_NOR = 6'b010001;
    localparam logic [5:0] FUN_STA = 6'b011010;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_SRL = 6'b100001;
    localparam logic [5:0] FUN_SRA = 6'b100011;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
    localparam logic [5:0] FUN_NEQ = 6'b110001;
    localparam logic [5:0] FUN_LT  = 6'b110101;
    localparam logic [5:0] FUN_LEZ = 6'b111101;
    localparam logic [5:0] FUN_GEZ = 6'b111001;
    localparam logic [5:0] FUN_GTZ = 6'b111111;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] ASEL_RS    = 2'd0;
    localparam logic [1:0] ASEL_SHAMT = 2'd1;
    localparam logic [1:0] ASEL_C16   = 2'd2;

    localparam logic [1:0] BSEL_RT   = 2'd0;
    localparam logic [1:0] BSEL_SEXT = 2'd1;
    localparam logic [1:0] BSEL_ZEXT = 2'd2;
    localparam logic [1:0] BSEL_ZERO = 2'd3;

    typedef struct packed {
        logic [5:0]  alufun;
        logic        sign;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [31:0] imm32;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Fetch-side valid/ready input plus execute-side decoded output of the issue stage.
// master = fetch/execute environment, slave = the issue stage.
interface alu_issue_stage_if;
    logic [31:0] iInstr;
    logic        iValid;
    logic        oReady;
    logic        iFlush;
    logic        iReady;
    logic        oValid;
    logic [5:0]  oALUFun;
    logic        oSign;
    logic [1:0]  oASel;
    logic [1:0]  oBSel;
    logic [31:0] oImm32;
    logic [4:0]  oShamt;
    logic [4:0]  oRs;
    logic [4:0]  oRt;
    logic [4:0]  oRd;
    logic        oIllegal;

    modport master (
        output iInstr, iValid, iFlush, iReady,
        input  oReady, oValid, oALUFun, oSign, oASel, oBSel, oImm32,
               oShamt, oRs, oRt, oRd, oIllegal
    );

    modport slave (
        input  iInstr, iValid, iFlush, iReady,
        output oReady, oValid, oALUFun, oSign, oASel, oBSel, oImm32,
               oShamt, oRs, oRt, oRd, oIllegal
    );
endinterface

// File: rtl/mips_alu_decode.sv
// Combinational MIPS instruction -> ALU control bundle decode.
// Latency 0; no handshake of its own.
module mips_alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        dec        = '0;
        dec.alufun = FUN_ADD;
        dec.shamt  = instr[10:6];
        dec.rs     = instr[25:21];
        dec.rt     = instr[20:16];
        dec.rd     = instr[15:11];
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dec.alufun = FUN_ADD; dec.sign = 1'b1; end
                    FN_ADDU: dec.alufun = FUN_ADD;
                    FN_SUB:  begin dec.alufun = FUN_SUB; dec.sign = 1'b1; end
                    FN_SUBU: dec.alufun = FUN_SUB;
                    FN_AND:  dec.alufun = FUN_AND;
                    FN_OR:   dec.alufun = FUN_OR;
                    FN_XOR:  dec.alufun = FUN_XOR;
                    FN_NOR:  dec.alufun = FUN_NOR;
                    FN_SLT:  begin dec.alufun = FUN_LT; dec.sign = 1'b1; end
                    FN_SLTU: dec.alufun = FUN_LT;
                    FN_SLL:  begin dec.alufun = FUN_SLL; dec.asel = ASEL_SHAMT; end
                    FN_SRL:  begin dec.alufun = FUN_SRL; dec.asel = ASEL_SHAMT; end
                    FN_SRA:  begin dec.alufun = FUN_SRA; dec.asel = ASEL_SHAMT; end
                    FN_JR:   dec.alufun = FUN_STA;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (instr[20:16])
                    5'd1:    begin dec.alufun = FUN_GEZ; dec.sign = 1'b1; end
                    5'd0:    begin dec.alufun = FUN_LT; dec.sign = 1'b1; dec.bsel = BSEL_ZERO; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec.alufun = FUN_ADD; dec.sign = 1'b1; dec.bsel = BSEL_SEXT; end
            OP_ADDIU: begin dec.alufun = FUN_ADD; dec.bsel = BSEL_SEXT; end
            OP_SLTI:  begin dec.alufun = FUN_LT; dec.sign = 1'b1; dec.bsel = BSEL_SEXT; end
            OP_SLTIU: begin dec.alufun = FUN_LT; dec.bsel = BSEL_SEXT; end
            OP_ANDI:  begin dec.alufun = FUN_AND; dec.bsel = BSEL_ZEXT; end
            OP_ORI:   begin dec.alufun = FUN_OR; dec.bsel = BSEL_ZEXT; end
            OP_XORI:  begin dec.alufun = FUN_XOR; dec.bsel = BSEL_ZEXT; end
            OP_LUI:   begin dec.alufun = FUN_SLL; dec.asel = ASEL_C16; dec.bsel = BSEL_ZEXT; end
            OP_LW,
            OP_SW:    begin dec.alufun = FUN_ADD; dec.bsel = BSEL_SEXT; end
            OP_BEQ:   begin dec.alufun = FUN_EQ; dec.sign = 1'b1; end
            OP_BNE:   begin dec.alufun = FUN_NEQ; dec.sign = 1'b1; end
            OP_BLEZ:  begin dec.alufun = FUN_LEZ; dec.sign = 1'b1; end
            OP_BGTZ:  begin dec.alufun = FUN_GTZ; dec.sign = 1'b1; end
            default:  dec.illegal = 1'b1;
        endcase
        // Immediate only carries meaning for the two extension selects.
        case (dec.bsel)
            BSEL_SEXT: dec.imm32 = {{16{instr[15]}}, instr[15:0]};
            BSEL_ZEXT: dec.imm32 = {16'h0000, instr[15:0]};
            default:   dec.imm32 = '0;
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode/issue stage: decoded bundle held in main entry M with skid entry S.
// Latency 1 cycle; ready is registered and drops only when S fills, so throughput is 1/cycle.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    alu_issue_stage_if.slave  bus
);
    dec_t dec;
    dec_t m_dat, m_dat_nxt;
    dec_t s_dat, s_dat_nxt;
    logic m_vld, m_vld_nxt;
    logic s_vld, s_vld_nxt;
    logic in_rdy;
    logic accept;
    logic consume;

    mips_alu_decode u_decode (
        .instr (bus.iInstr),
        .dec   (dec)
    );

    assign accept  = bus.iValid && in_rdy;
    assign consume = m_vld && bus.iReady;

    // in_rdy mirrors !s_vld outside reset, so an accept never coincides with a full S.
    always_comb begin
        m_dat_nxt = m_dat;
        s_dat_nxt = s_dat;
        m_vld_nxt = m_vld;
        s_vld_nxt = s_vld;
        if (bus.iFlush) begin
            m_vld_nxt = 1'b0;
            s_vld_nxt = 1'b0;
        end else if (!m_vld || consume) begin
            if (s_vld) begin
                m_dat_nxt = s_dat;
                m_vld_nxt = 1'b1;
                s_vld_nxt = 1'b0;
            end else begin
                m_vld_nxt = accept;
                if (accept) m_dat_nxt = dec;
            end
        end else if (accept) begin
            s_dat_nxt = dec;
            s_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            m_dat  <= '0;
            s_dat  <= '0;
            m_vld  <= 1'b0;
            s_vld  <= 1'b0;
            in_rdy <= 1'b0;
        end else begin
            m_dat  <= m_dat_nxt;
            s_dat  <= s_dat_nxt;
            m_vld  <= m_vld_nxt;
            s_vld  <= s_vld_nxt;
            in_rdy <= !s_vld_nxt;
        end
    end

    assign bus.oReady   = in_rdy;
    assign bus.oValid   = m_vld;
    assign bus.oALUFun  = m_dat.alufun;
    assign bus.oSign    = m_dat.sign;
    assign bus.oASel    = m_dat.asel;
    assign bus.oBSel    = m_dat.bsel;
    assign bus.oImm32   = m_dat.imm32;
    assign bus.oShamt   = m_dat.shamt;
    assign bus.oRs      = m_dat.rs;
    assign bus.oRt      = m_dat.rt;
    assign bus.oRd      = m_dat.rd;
    assign bus.oIllegal = m_dat.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode/handshake scenarios plus a randomized stream,
// checked against a table-driven decode model and a queue model of the buffered entries.
module tb_alu_issue_stage;
    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] q[$];
    bit          rdy_hold;
    logic [22:0] tbl[$];     // {key12, fun6, sign1, asel2, bsel2}
    logic [5:0]  fn_pool[16];
    logic [5:0]  op_pool[16];

    function automatic logic [22:0] row(input logic [11:0] key, input logic [5:0] fun,
                                        input logic sgn, input logic [1:0] a, input logic [1:0] b);
        return {key, fun, sgn, a, b};
    endfunction

    function automatic logic [63:0] ref_dec(input logic [31:0] ins);
        logic [11:0] key;
        logic [5:0]  fun;
        logic        sgn;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        ill;
        logic [31:0] imm;
        if (ins[31:26] == 6'h00)      key = {6'h00, ins[5:0]};
        else if (ins[31:26] == 6'h01) key = {6'h01, 1'b0, ins[20:16]};
        else                          key = {ins[31:26], 6'h3F};
        fun = 6'b000000; sgn = 1'b0; a = 2'd0; b = 2'd0; ill = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i][22:11] == key) begin
                {fun, sgn, a, b} = tbl[i][10:0];
                ill = 1'b0;
            end
        end
        if (b == 2'd1)      imm = {{16{ins[15]}}, ins[15:0]};
        else if (b == 2'd2) imm = {16'h0000, ins[15:0]};
        else                imm = 32'h0;
        return {fun, sgn, a, b, imm, ins[10:6], ins[25:21], ins[20:16], ins[15:11], ill};
    endfunction

    function automatic logic [63:0] obs();
        return {bus.oALUFun, bus.oSign, bus.oASel, bus.oBSel, bus.oImm32,
                bus.oShamt, bus.oRs, bus.oRt, bus.oRd, bus.oIllegal};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called at a falling edge: compare outputs with the model, drive the next inputs,
    // then advance the model by the rising edge that follows.
    task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic f);
        bit exp_rdy;
        exp_rdy = !rdy_hold && (q.size() < 2);
        chk("valid", bus.oValid, q.size() > 0);
        chk("ready", bus.oReady, exp_rdy);
        if (q.size() > 0) chk("fields", obs(), ref_dec(q[0]));
        bus.iValid = v;
        bus.iInstr = ins;
        bus.iReady = r;
        bus.iFlush = f;
        if (f) q.delete();
        else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(ins);
        end
        rdy_hold = 1'b0;
        @(negedge iClk);
    endtask

    task automatic do_reset();
        iRst_n     = 1'b0;
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        bus.iFlush = 1'b0;
        @(negedge iClk);
        chk("rst_fields", obs(), 64'h0);
        chk("rst_vld_rdy", {bus.oValid, bus.oReady}, 2'b00);
        iRst_n   = 1'b1;
        q.delete();
        rdy_hold = 1'b1;
    endtask

    task automatic dchk(input string tag, input logic [31:0] ins, input logic [5:0] fun,
                        input logic sgn, input logic [1:0] a, input logic [1:0] b,
                        input logic [31:0] imm, input logic ill);
        step(1'b1, ins, 1'b1, 1'b0);
        chk(tag, {bus.oValid, bus.oALUFun, bus.oSign, bus.oASel, bus.oBSel, bus.oImm32, bus.oIllegal},
            {1'b1, fun, sgn, a, b, imm, ill});
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 3))
            0: begin ins[31:26] = 6'h00; ins[5:0] = fn_pool[$urandom_range(0, 15)]; end
            1: ins[31:26] = op_pool[$urandom_range(0, 15)];
            2: begin ins[31:26] = 6'h01; ins[20:16] = 5'($urandom_range(0, 2)); end
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        logic [31:0] seq[6];
        int          idx;

        bus.iInstr = 32'h0;
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        bus.iFlush = 1'b0;

        tbl.push_back(row({6'h00, 6'h20}, 6'b000000, 1, 0, 0));
        tbl.push_back(row({6'h00, 6'h21}, 6'b000000, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h22}, 6'b000001, 1, 0, 0));
        tbl.push_back(row({6'h00, 6'h23}, 6'b000001, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h24}, 6'b011000, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h25}, 6'b011110, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h26}, 6'b010110, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h27}, 6'b010001, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h2A}, 6'b110101, 1, 0, 0));
        tbl.push_back(row({6'h00, 6'h2B}, 6'b110101, 0, 0, 0));
        tbl.push_back(row({6'h00, 6'h00}, 6'b100000, 0, 1, 0));
        tbl.push_back(row({6'h00, 6'h02}, 6'b100001, 0, 1, 0));
        tbl.push_back(row({6'h00, 6'h03}, 6'b100011, 0, 1, 0));
        tbl.push_back(row({6'h00, 6'h08}, 6'b011010, 0, 0, 0));
        tbl.push_back(row({6'h01, 6'h01}, 6'b111001, 1, 0, 0));
        tbl.push_back(row({6'h01, 6'h00}, 6'b110101, 1, 0, 3));
        tbl.push_back(row({6'h08, 6'h3F}, 6'b000000, 1, 0, 1));
        tbl.push_back(row({6'h09, 6'h3F}, 6'b000000, 0, 0, 1));
        tbl.push_back(row({6'h0A, 6'h3F}, 6'b110101, 1, 0, 1));
        tbl.push_back(row({6'h0B, 6'h3F}, 6'b110101, 0, 0, 1));
        tbl.push_back(row({6'h0C, 6'h3F}, 6'b011000, 0, 0, 2));
        tbl.push_back(row({6'h0D, 6'h3F}, 6'b011110, 0, 0, 2));
        tbl.push_back(row({6'h0E, 6'h3F}, 6'b010110, 0, 0, 2));
        tbl.push_back(row({6'h0F, 6'h3F}, 6'b100000, 0, 2, 2));
        tbl.push_back(row({6'h23, 6'h3F}, 6'b000000, 0, 0, 1));
        tbl.push_back(row({6'h2B, 6'h3F}, 6'b000000, 0, 0, 1));
        tbl.push_back(row({6'h04, 6'h3F}, 6'b110011, 1, 0, 0));
        tbl.push_back(row({6'h05, 6'h3F}, 6'b110001, 1, 0, 0));
        tbl.push_back(row({6'h06, 6'h3F}, 6'b111101, 1, 0, 0));
        tbl.push_back(row({6'h07, 6'h3F}, 6'b111111, 1, 0, 0));

        fn_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h3F};
        op_pool = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h02, 6'h3F};

        @(negedge iClk);
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ready_after_reset", bus.oReady, 1'b1);

        // Directed decode points
        dchk("dec_add", 32'h00221820, 6'b000000, 1'b1, 2'd0, 2'd0, 32'h0, 1'b0);
        step(1'b1, 32'h00221820, 1'b1, 1'b0);
        chk("dec_add_regs", {bus.oRs, bus.oRt, bus.oRd}, {5'd1, 5'd2, 5'd3});
        step(1'b0, 32'h0, 1'b1, 1'b0);
        dchk("dec_lui", 32'h3C011234, 6'b100000, 1'b0, 2'd2, 2'd2, 32'h00001234, 1'b0);
        dchk("dec_addi", 32'h2021FFFF, 6'b000000, 1'b1, 2'd0, 2'd1, 32'hFFFFFFFF, 1'b0);
        dchk("dec_illegal", 32'hFC000000, 6'b000000, 1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
        dchk("dec_bltz", 32'h04200003, 6'b110101, 1'b1, 2'd0, 2'd3, 32'h0, 1'b0);
        dchk("dec_bgez", 32'h04210003, 6'b111001, 1'b1, 2'd0, 2'd0, 32'h0, 1'b0);

        // Backpressure: continuous offer of I0..I5, execute stalls for three cycles
        foreach (seq[i]) seq[i] = rnd_instr();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            bit stall;
            bit acc;
            stall = (c >= 1 && c <= 3);
            acc   = (idx < 6) && !rdy_hold && (q.size() < 2);
            step(idx < 6, (idx < 6) ? seq[idx] : 32'h0, !stall, 1'b0);
            if (acc) idx++;
            if (c == 1) chk("bp_ready_low", bus.oReady, 1'b0);
        end
        chk("bp_all_sent", idx, 6);
        chk("bp_drained", bus.oValid, 1'b0);

        // Flush with both entries full and a same-cycle offer
        step(1'b1, 32'h00221820, 1'b0, 1'b0);
        step(1'b1, 32'h3C011234, 1'b0, 1'b0);
        chk("flush_pre_full", {bus.oValid, bus.oReady}, 2'b10);
        step(1'b1, 32'h2021FFFF, 1'b0, 1'b1);
        chk("flush_vld_rdy", {bus.oValid, bus.oReady}, 2'b01);
        step(1'b1, 32'h04210003, 1'b0, 1'b0);
        chk("flush_next", {bus.oValid, bus.oALUFun}, {1'b1, 6'b111001});
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset in the middle of a stall
        step(1'b1, 32'h00221820, 1'b0, 1'b0);
        step(1'b1, 32'h3C011234, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'h2021FFFF, 1'b1, 1'b0);
        chk("rst_ready_up", {bus.oValid, bus.oReady}, 2'b01);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        end
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
